// File: rtl/fp_pkg.sv
// +----------------------------------------------------------------------------+
// | fp_pkg: shared types and constants for the binary32 round/pack datapath.   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

package fp_pkg;

  localparam int          EXP_BIAS   = 127;
  localparam int          EXP_MAX    = 255;
  localparam logic [31:0] POS_INF    = 32'h7F80_0000;
  localparam logic [31:0] MAX_FINITE = 32'h7F7F_FFFF;

  // Working exponent is signed and wide enough for in_exp + sext(shift) + carry.
  localparam int E_W      = 10;
  localparam int SIG_BITS = 24;

  typedef enum logic [2:0] {
    RNE = 3'b000,
    RTZ = 3'b001,
    RDN = 3'b010,
    RUP = 3'b011,
    RMM = 3'b100
  } rm_e;

  typedef struct packed {
    logic nv;
    logic dz;
    logic of;
    logic uf;
    logic nx;
  } fflags_t;

  typedef struct packed {
    logic                sign;
    logic [E_W-1:0]      e;
    logic [SIG_BITS-1:0] sig;
    logic                inc;
    logic                nx;
    logic                nv;
    rm_e                 rm;
    logic                zero;
    logic                special;
    logic [31:0]         special_val;
  } s1_t;

endpackage

`default_nettype wire

// File: rtl/fp_round_inc.sv
// +----------------------------------------------------------------------------+
// | fp_round_inc: rounding-increment decision from RISC-V rm and L/G/R/S bits. |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module fp_round_inc
  import fp_pkg::*;
(
  input  logic [2:0] rm,
  input  logic       sign,
  input  logic       lsb,
  input  logic       guard,
  input  logic       round,
  input  logic       sticky,
  output logic       inc,
  output logic       nx,
  output logic       nv,
  output logic [2:0] rm_eff
);

  rm_e w_rm;

  always_comb begin
    w_rm = RNE;
    nv   = 1'b0;
    case (rm)
      3'b000:  w_rm = RNE;
      3'b001:  w_rm = RTZ;
      3'b010:  w_rm = RDN;
      3'b011:  w_rm = RUP;
      3'b100:  w_rm = RMM;
      // Reserved encodings fall back to round-to-nearest-even and raise NV.
      default: begin
        w_rm = RNE;
        nv   = 1'b1;
      end
    endcase
  end

  always_comb begin
    nx  = guard | round | sticky;
    inc = 1'b0;
    case (w_rm)
      RNE:     inc = guard & (round | sticky | lsb);
      RTZ:     inc = 1'b0;
      RDN:     inc = sign & nx;
      RUP:     inc = ~sign & nx;
      RMM:     inc = guard;
      default: inc = 1'b0;
    endcase
  end

  assign rm_eff = w_rm;

endmodule

`default_nettype wire

// File: rtl/fp_round_pack.sv
// +----------------------------------------------------------------------------+
// | fp_round_pack: exponent adjust, round, renormalize and pack binary32 with  |
// | fflags through a 2-stage valid/ready pipeline.  Rev 1.0                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module fp_round_pack
  import fp_pkg::*;
#(
  parameter int EXP_W         = 8,
  parameter int SIG_W         = 24,
  parameter int FLUSH_SUBNORM = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sign,
  input  logic [EXP_W-1:0] in_exp,
  input  logic [7:0]       in_shift,
  input  logic [SIG_W-1:0] in_sig,
  input  logic [2:0]       in_grs,
  input  logic             in_zero,
  input  logic             in_special,
  input  logic [31:0]      in_special_val,
  input  logic [2:0]       in_rm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_result,
  output logic [4:0]       out_flags
);

  // ---------------------------------------------------------------- handshake
  logic r_s1_valid;
  logic r_s2_valid;
  logic w_s1_adv;

  assign w_s1_adv  = ~r_s2_valid | out_ready;
  assign in_ready  = ~r_s1_valid | w_s1_adv;
  assign out_valid = r_s2_valid;

  // ---------------------------------------------------------------- stage 1
  logic [E_W-1:0] w_e;
  logic           w_inc;
  logic           w_nx;
  logic           w_nv;
  logic [2:0]     w_rm_eff;
  s1_t            w_s1_next;
  s1_t            r_s1;

  assign w_e = {{(E_W-EXP_W){1'b0}}, in_exp} + {{(E_W-8){in_shift[7]}}, in_shift};

  fp_round_inc u_round_inc (
    .rm     (in_rm),
    .sign   (in_sign),
    .lsb    (in_sig[0]),
    .guard  (in_grs[2]),
    .round  (in_grs[1]),
    .sticky (in_grs[0]),
    .inc    (w_inc),
    .nx     (w_nx),
    .nv     (w_nv),
    .rm_eff (w_rm_eff)
  );

  always_comb begin
    w_s1_next             = '0;
    w_s1_next.sign        = in_sign;
    w_s1_next.e           = w_e;
    w_s1_next.sig         = in_sig;
    w_s1_next.inc         = w_inc;
    w_s1_next.nx          = w_nx;
    w_s1_next.nv          = w_nv;
    w_s1_next.rm          = rm_e'(w_rm_eff);
    w_s1_next.zero        = in_zero;
    w_s1_next.special     = in_special;
    w_s1_next.special_val = in_special_val;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1       <= '0;
    end else if (in_ready) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1 <= w_s1_next;
      end
    end
  end

  // ---------------------------------------------------------------- stage 2
  logic [SIG_W:0]   w_sum;
  logic             w_carry;
  logic [SIG_W-2:0] w_mant;
  logic [E_W-1:0]   w_e_rnd;
  logic             w_uf;
  logic             w_of;
  logic             w_to_inf;
  logic [31:0]      w_res;
  fflags_t          w_flg;
  logic             unused_hidden;

  assign w_sum         = {1'b0, r_s1.sig} + {{SIG_W{1'b0}}, r_s1.inc};
  assign w_carry       = w_sum[SIG_W];
  assign unused_hidden = w_sum[SIG_W-1];
  // A round carry means the significand was all ones: the value becomes 1.0 x 2^(e+1).
  assign w_mant        = w_carry ? '0 : w_sum[SIG_W-2:0];
  assign w_e_rnd       = r_s1.e + {{(E_W-1){1'b0}}, w_carry};

  // Underflow uses the pre-round exponent; overflow uses the post-carry one.
  assign w_uf = (FLUSH_SUBNORM != 0) && (int'($signed(r_s1.e)) <= 0);
  assign w_of = int'($signed(w_e_rnd)) >= EXP_MAX;

  always_comb begin
    w_to_inf = 1'b1;
    case (r_s1.rm)
      RTZ:     w_to_inf = 1'b0;
      RDN:     w_to_inf = r_s1.sign;
      RUP:     w_to_inf = ~r_s1.sign;
      default: w_to_inf = 1'b1;
    endcase
  end

  always_comb begin
    w_res    = {r_s1.sign, w_e_rnd[EXP_W-1:0], w_mant};
    w_flg    = '0;
    w_flg.nv = r_s1.nv;
    w_flg.nx = r_s1.nx;
    if (r_s1.special) begin
      w_res    = r_s1.special_val;
      w_flg    = '0;
      w_flg.nv = r_s1.nv;
    end else if (r_s1.zero) begin
      w_res = {r_s1.sign, 31'b0};
      w_flg = '0;
    end else if (w_uf) begin
      w_res    = {r_s1.sign, 31'b0};
      w_flg.uf = 1'b1;
      w_flg.nx = 1'b1;
    end else if (w_of) begin
      w_res    = (w_to_inf ? POS_INF : MAX_FINITE) | {r_s1.sign, 31'b0};
      w_flg.of = 1'b1;
      w_flg.nx = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid <= 1'b0;
      out_result <= '0;
      out_flags  <= '0;
    end else if (w_s1_adv) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        out_result <= w_res;
        out_flags  <= w_flg;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fp_round_pack.sv
// +----------------------------------------------------------------------------+
// | tb_fp_round_pack: scoreboard bench with directed and random stimulus.      |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_fp_round_pack;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [7:0]  in_exp;
  logic [7:0]  in_shift;
  logic [23:0] in_sig;
  logic [2:0]  in_grs;
  logic        in_zero;
  logic        in_special;
  logic [31:0] in_special_val;
  logic [2:0]  in_rm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [4:0]  out_flags;

  always #5 clk = ~clk;

  fp_round_pack #(.EXP_W(8), .SIG_W(24), .FLUSH_SUBNORM(1)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_sign        (in_sign),
    .in_exp         (in_exp),
    .in_shift       (in_shift),
    .in_sig         (in_sig),
    .in_grs         (in_grs),
    .in_zero        (in_zero),
    .in_special     (in_special),
    .in_special_val (in_special_val),
    .in_rm          (in_rm),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_result     (out_result),
    .out_flags      (out_flags)
  );

  typedef struct {
    bit        sign;
    bit [7:0]  exp;
    bit [7:0]  shift;
    bit [23:0] sig;
    bit [2:0]  grs;
    bit        zero;
    bit        special;
    bit [31:0] sval;
    bit [2:0]  rm;
  } beat_t;

  typedef struct {
    bit [31:0] res;
    bit [4:0]  flg;
    int        cyc;
    bit        lat;
  } exp_t;

  exp_t exp_q[$];
  int   pop_cyc[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   n_acc = 0;
  int   cyc   = 0;
  int   bp_base = 0;
  bit   bp_chk  = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    if (act !== req) begin
      $display("FAIL %s: got %h want %h", name, act, req);
      n_err++;
    end
  endtask

  // Reference: value-level rounding of the real number sig * 2^(e-150) into binary32.
  function automatic void model(input beat_t b, output bit [31:0] res, output bit [4:0] flg);
    int  e, mode;
    bit  nv, nx, up, big;
    longint m;
    e    = int'(b.exp) + int'($signed(b.shift));
    nv   = (b.rm > 3'd4);
    mode = nv ? 0 : int'(b.rm);
    nx   = (b.grs != 3'b000);
    case (mode)
      0:       up = b.grs[2] && (b.grs[1] || b.grs[0] || b.sig[0]);
      1:       up = 1'b0;
      2:       up = b.sign && nx;
      3:       up = !b.sign && nx;
      default: up = b.grs[2];
    endcase
    if (b.special) begin
      res = b.sval;
      flg = {nv, 4'b0000};
    end else if (b.zero) begin
      res = {b.sign, 31'b0};
      flg = 5'b00000;
    end else if (e <= 0) begin
      res = {b.sign, 31'b0};
      flg = {nv, 4'b0011};
    end else begin
      m = longint'(b.sig) + (up ? 1 : 0);
      if (m >= (longint'(1) << 24)) begin
        m = m / 2;
        e = e + 1;
      end
      if (e >= 255) begin
        big = (mode == 0) || (mode == 4) || (mode == 2 && b.sign) || (mode == 3 && !b.sign);
        res = big ? {b.sign, 8'hFF, 23'd0} : {b.sign, 8'hFE, 23'h7FFFFF};
        flg = {nv, 4'b0101};
      end else begin
        res = {b.sign, e[7:0], m[22:0]};
        flg = {nv, 3'b000, nx};
      end
    end
  endfunction

  function automatic beat_t rand_beat();
    beat_t b;
    b.sign  = 1'($urandom_range(0, 1));
    b.exp   = 8'($urandom_range(0, 255));
    b.shift = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 8) - 4);
    b.sig   = ($urandom_range(0, 7) == 0) ? 24'hFFFFFF : {1'b1, 23'($urandom)};
    b.grs   = 3'($urandom_range(0, 7));
    b.zero  = ($urandom_range(0, 15) == 0);
    b.special = ($urandom_range(0, 15) == 0);
    b.sval  = $urandom;
    b.rm    = 3'($urandom_range(0, 4));
    return b;
  endfunction

  function automatic beat_t mk(input bit sign, input bit [7:0] exp, input bit [7:0] shift,
                               input bit [23:0] sig, input bit [2:0] grs, input bit [2:0] rm);
    beat_t b;
    b.sign = sign; b.exp = exp; b.shift = shift; b.sig = sig; b.grs = grs;
    b.zero = 1'b0; b.special = 1'b0; b.sval = 32'd0; b.rm = rm;
    return b;
  endfunction

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input beat_t b, input bit [31:0] res, input bit [4:0] flg, input bit lat);
    int   waitc = 0;
    exp_t e;
    in_sign = b.sign; in_exp = b.exp; in_shift = b.shift; in_sig = b.sig; in_grs = b.grs;
    in_zero = b.zero; in_special = b.special; in_special_val = b.sval; in_rm = b.rm;
    in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      if (bp_chk) begin
        bp_chk = 1'b0;
        chk("bp_ready_drop_after", 32'(n_acc - bp_base), 32'd2);
      end
      waitc++;
      if (waitc > 60) begin
        $display("FAIL in_ready_timeout: got stalled %0d cycles want accept", waitc);
        n_err++;
        @(posedge clk); #1;
        in_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    e.res = res; e.flg = flg; e.cyc = cyc; e.lat = lat;
    exp_q.push_back(e);
    n_acc++;
    n_vec++;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send_m(input beat_t b, input bit lat);
    bit [31:0] r;
    bit [4:0]  f;
    model(b, r, f);
    send(b, r, f, lat);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    #1;
    if (exp_q.size() != 0) begin
      $display("FAIL drain_timeout: got %0d pending want 0", exp_q.size());
      n_err++;
      exp_q.delete();
    end
  endtask

  // Monitor: pops the scoreboard on each output transfer, checks stall stability.
  bit          held = 1'b0;
  logic [31:0] held_r;
  logic [4:0]  held_f;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      held = 1'b0;
    end else begin
      if (held) begin
        if (!out_valid) begin
          $display("FAIL stall_drop: got out_valid 0 want 1");
          n_err++;
        end else begin
          chk("stall_result", out_result, held_r);
          chk("stall_flags", 32'(out_flags), 32'(held_f));
        end
      end
      held   = out_valid && !out_ready;
      held_r = out_result;
      held_f = out_flags;
      if (out_valid && out_ready) begin
        pop_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          $display("FAIL unexpected_out: got %h want none", out_result);
          n_err++;
        end else begin
          e = exp_q.pop_front();
          chk("result", out_result, e.res);
          chk("flags", 32'(out_flags), 32'(e.flg));
          if (e.lat) chk("latency", 32'(cyc - e.cyc), 32'd2);
        end
      end
    end
  end

  bit rnd_done = 1'b0;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_sign = 0; in_exp = 0; in_shift = 0; in_sig = 0; in_grs = 0;
    in_zero = 0; in_special = 0; in_special_val = 0; in_rm = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_result", out_result, 32'd0);
    chk("rst_out_flags", 32'(out_flags), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // Directed cases with hand-derived expectations.
    send(mk(0, 8'd127, 8'd0, 24'h800000, 3'b000, 3'd0), 32'h3F800000, 5'b00000, 1);
    drain();
    send(mk(0, 8'd127, 8'd0, 24'hFFFFFF, 3'b100, 3'd0), 32'h40000000, 5'b00001, 1);
    send(mk(0, 8'd127, 8'd0, 24'hFFFFFF, 3'b100, 3'd1), 32'h3FFFFFFF, 5'b00001, 1);
    send(mk(0, 8'd254, 8'd1, 24'h800000, 3'b000, 3'd0), 32'h7F800000, 5'b00101, 1);
    send(mk(0, 8'd254, 8'd1, 24'h800000, 3'b000, 3'd1), 32'h7F7FFFFF, 5'b00101, 1);
    send(mk(1, 8'd254, 8'd1, 24'h800000, 3'b000, 3'd3), 32'hFF7FFFFF, 5'b00101, 1);
    send(mk(1, 8'd1, 8'hFD, 24'h800000, 3'b000, 3'd0), 32'h80000000, 5'b00011, 1);
    drain();

    // Backpressure: four beats back to back, consumer stalled three cycles.
    pop_cyc.delete();
    out_ready = 1'b0;
    bp_base   = n_acc;
    bp_chk    = 1'b1;
    fork
      begin
        for (int i = 0; i < 4; i++) send_m(rand_beat(), 0);
      end
      begin
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();
    if (bp_chk) begin
      $display("FAIL bp_ready_drop: got in_ready never low want low after 2");
      n_err++;
      bp_chk = 1'b0;
    end
    chk("bp_out_count", 32'(pop_cyc.size()), 32'd4);
    if (pop_cyc.size() == 4) chk("bp_no_bubble", 32'(pop_cyc[3] - pop_cyc[0]), 32'd3);

    // Reset with both stages full: nothing may emerge afterwards.
    out_ready = 1'b0;
    send_m(rand_beat(), 0);
    send_m(rand_beat(), 0);
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("async_rst_out_valid", 32'(out_valid), 32'd0);
    chk("async_rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("rst_no_stale", 32'(out_valid), 32'd0);

    begin
      beat_t b;
      b = mk(0, 8'd0, 8'd0, 24'd0, 3'b000, 3'd5);
      b.special = 1'b1;
      b.sval    = 32'h7FC00000;
      send(b, 32'h7FC00000, 5'b10000, 1);
    end
    drain();

    // Random traffic with random consumer backpressure.
    fork
      begin
        for (int i = 0; i < 400; i++) begin
          send_m(rand_beat(), 0);
          if ($urandom_range(0, 7) == 0) begin
            @(posedge clk); #1;
          end
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fp_round_pack.md
Name: fp_round_pack

Overview:
- Stage directly downstream of normalize in the single-precision FP add/sub datapath.
- Consumes the normalized significand, guard/round/sticky bits, biased exponent and normalize shift.
- Applies the exponent adjustment, rounds per the RISC-V rounding mode and renormalizes on round carry.
- Detects overflow/underflow and packs an IEEE-754 binary32 result with fflags, through a 2-stage valid/ready pipeline.

Parameters:
- EXP_W, 8, biased exponent width.
- SIG_W, 24, significand width including the hidden bit.
- FLUSH_SUBNORM, 1, flush results with adjusted exponent <= 0 to signed zero (only 1 is supported).

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  input beat valid.
- in_ready  output  1  stage can accept a beat.
- in_sign  input  1  result sign.
- in_exp  input  8  biased exponent before normalization.
- in_shift  input  8  normalize shift, two's complement (+ = right, - = left).
- in_sig  input  24  normalized significand; bit 23 is the hidden 1.
- in_grs  input  3  guard, round, sticky aligned below in_sig[0].
- in_zero  input  1  exact-zero result (normalize input was 0).
- in_special  input  1  bypass: upstream already resolved NaN/Inf.
- in_special_val  input  32  packed result used when in_special.
- in_rm  input  3  RISC-V frm: 000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts.
- out_result  output  32  packed binary32.
- out_flags  output  5  {NV, DZ, OF, UF, NX}.

Behaviour:
- Reset: all stage-valid bits, out_valid, out_result and out_flags are 0; in_ready is 1 after reset.
- Asynchronous reset mid-operation discards in-flight beats; no output is produced for them.
- Handshake:
  - Transfer occurs when valid && ready. Latency is exactly 2 cycles with out_ready held high; throughput is 1 beat/cycle.
  - s1_adv = !s2_valid || out_ready; in_ready = !s1_valid || s1_adv (combinational, no in_valid dependence).
  - out_* hold stable while out_valid && !out_ready. Order is preserved; no beat is dropped or duplicated.
- Stage 1 (registered):
  - e = in_exp + sext(in_shift), 10-bit signed.
  - nx = |in_grs.
  - inc per rm, with L = in_sig[0] and {G,R,S} = in_grs:
    - RNE: G & (R|S|L)
    - RTZ: 0
    - RDN: sign & nx
    - RUP: !sign & nx
    - RMM: G
  - rm 101/110/111: treated as RNE and NV is set.
- Stage 2 (registered):
  - s = {1'b0,sig} + inc (25 bits). If s[24], mantissa = 0 and e = e+1; otherwise mantissa = s[22:0].
- Priority order in stage 2:
  1. in_special: result = in_special_val, flags 0 (except NV from bad rm).
  2. in_zero: result = {sign,31'b0}, flags 0.
  3. e <= 0, checked on the pre-round e: result = {sign,31'b0}; UF = 1, NX = 1.
  4. e >= 255, checked after the round carry: OF = 1, NX = 1. RNE/RMM give ±Inf. RTZ gives ±max-finite (0x7F7FFFFF | sign). RDN gives -Inf for negative, +max-finite for positive. RUP gives +Inf for positive, -max-finite for negative.
  5. Otherwise: {sign, e[7:0], mantissa}, with NX = nx.
- DZ is always 0.
- Simultaneous in/out handshakes in one cycle are legal and must not bubble.

Decomposition:
- Package fp_pkg:
  - typedef rm_e (RNE, RTZ, RDN, RUP, RMM).
  - typedef fflags_t packed struct {nv, dz, of, uf, nx}.
  - Constants EXP_BIAS=127, EXP_MAX=255, POS_INF=32'h7F800000, MAX_FINITE=32'h7F7FFFFF.
  - typedef s1_t (stage-1 payload struct).
- Sub-module fp_round_inc: combinational rounding-increment decision (rm, sign, L, G, R, S -> inc, nx). It is reused by the future multiplier pipeline.

Test Plan:
- sign0, exp127, shift0, sig 0x800000, grs000, RNE -> result 0x3F800000, flags 0, out_valid exactly 2 cycles after the accept.
- sig 0xFFFFFF, grs100, exp127, shift0, RNE -> tie with L=1 rounds up, carry -> 0x40000000, NX=1; same input with RTZ -> 0x3FFFFFFF, NX=1.
- exp254, shift+1, sig 0x800000, grs000 -> RNE 0x7F800000 with OF|NX; RTZ 0x7F7FFFFF with OF|NX; sign1 with RUP -> 0xFF7FFFFF.
- sign1, exp1, shift 0xFD (-3), sig 0x800000, grs000 -> 0x80000000 with UF|NX.
- Backpressure: stream 4 beats with out_ready low for 3 cycles:
  - in_ready drops after 2 accepted.
  - out_result is stable while stalled.
  - All 4 beats emerge in order with no bubble once out_ready rises.
- Both stages valid, assert rst_n=0 for 1 cycle -> out_valid=0 immediately, no stale result afterwards; in_special=1 with val 0x7FC00000 and rm=101 -> 0x7FC00000 with NV=1.
